branch_notif_receiver: RTL and testbench
========================================

BRANCH_NOTIF_RECEIVER -- requirements
Module: branch_notif_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): BTB-update FIFO entries.
REQ-002 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-003 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port branch_notif_valid, input, 1: notification from BRU pipeline is present.
REQ-005 SHALL have port branch_notif_ROB_index, input, LOG_ROB_ENTRIES: ROB index of the branch.
REQ-006 SHALL have ports branch_notif_is_mispredict, branch_notif_is_taken, branch_notif_is_out_of_range, branch_notif_pred_lru, each input, 1: the named outcome flags.
REQ-007 SHALL have port branch_notif_updated_pred_info, input, BTB_PRED_INFO_WIDTH: new prediction info.
REQ-008 SHALL have ports branch_notif_start_PC and branch_notif_target_PC, each input, 32: branch PC and resolved target.
REQ-009 SHALL have port branch_notif_ready, output, 1: notification accepted this cycle.
REQ-010 SHALL have port rob_head_index, input, LOG_ROB_ENTRIES: oldest live ROB entry, used for age comparison.
REQ-011 SHALL have port rob_flush, input, 1: ROB has taken a restart; discard any pending restart.
REQ-012 SHALL have outputs btb_update_valid (1), btb_update_start_PC (32), btb_update_target_PC (32), btb_update_pred_info (BTB_PRED_INFO_WIDTH), btb_update_pred_lru (1), btb_update_is_taken (1); input btb_update_ready (1).
REQ-013 SHALL have outputs restart_valid (1), restart_PC (32), restart_ROB_index (LOG_ROB_ENTRIES); input restart_ready (1).

Function
REQ-014 SHALL accept a notification when branch_notif_valid && branch_notif_ready.
REQ-015 SHALL drive branch_notif_ready = 1 iff the BTB FIFO is not full, or a FIFO pop occurs in the same cycle.
REQ-016 SHALL push an accepted notification into the FIFO only if is_out_of_range = 0; out-of-range notifications produce no BTB update.
REQ-017 SHALL present the FIFO head on btb_update_* with btb_update_valid = !empty and pop on btb_update_valid && btb_update_ready; simultaneous push and pop when full SHALL be legal.
REQ-018 SHALL give FIFO pointers log2(FIFO_DEPTH)+1 bits with wrap-around; full = MSBs differ and low bits equal.
REQ-019 SHALL define age as (ROB_index - rob_head_index) mod ROB_ENTRIES; a smaller value is older.
REQ-020 SHALL, on an accepted mispredict, load the restart register (PC = target_PC, ROB_index) when no restart is pending or the new branch is strictly older than the pending one; otherwise SHALL drop it.
REQ-021 SHALL raise restart_valid one cycle after load and hold restart_valid, restart_PC and restart_ROB_index stable until restart_valid && restart_ready, then clear.
REQ-022 SHALL give an older mispredict arriving in the cycle a pending restart handshakes priority: the new restart is loaded and restart_valid stays 1.
REQ-023 SHALL, on rob_flush, clear the pending restart the next cycle, with rob_flush taking priority over a same-cycle load. The FIFO SHALL be unaffected.

Reset
REQ-024 SHALL, when RST is high at a clock edge, empty the FIFO and clear the restart register; all valid outputs SHALL be 0, branch_notif_ready SHALL be 1, and data outputs SHALL be 0.
REQ-025 SHALL have mid-operation reset discard in-flight FIFO entries and any pending restart with no handshake completion.

Configuration
REQ-026 SHALL gate a FIFO bypass with macro BRANCH_NOTIF_RECEIVER_BYPASS_EN.
- Defined: when the FIFO is empty and btb_update_ready = 1, an accepted in-range notification drives btb_update_* combinationally in the same cycle and is not pushed.
- Undefined: minimum BTB-update latency is 1 cycle.

Verification
REQ-027 SHALL cover reset: assert RST mid-stream with 3 FIFO entries -> next cycle btb_update_valid = 0, restart_valid = 0, branch_notif_ready = 1.
REQ-028 SHALL cover fill/backpressure: btb_update_ready = 0, 5 in-range notifications with FIFO_DEPTH = 4 -> ready drops after the 4th; releasing ready drains in order with start_PC 0x100, 0x104, 0x108, 0x10C, then the 5th.
REQ-029 SHALL cover the out-of-range filter: notification with is_out_of_range = 1 and is_mispredict = 1, target 0x2000 -> no BTB update, restart_PC = 0x2000.
REQ-030 SHALL cover age priority with wrap: head = 30, ROB_ENTRIES = 32, pending mispredict idx 2, new mispredict idx 31 -> restart replaced by idx 31; a following idx 5 mispredict is dropped.
REQ-031 SHALL cover flush priority: rob_flush coincident with an accepted mispredict -> restart_valid = 0 next cycle.
REQ-032 SHALL cover the bypass build: BRANCH_NOTIF_RECEIVER_BYPASS_EN defined, empty FIFO, btb_update_ready = 1 -> btb_update_valid = 1 in the accept cycle; without the macro -> 1 cycle later.

Source files
------------

// File: rtl/branch_notif_receiver.sv
// Branch-resolution receiver: queues BTB updates in a small FIFO and keeps the oldest pending mispredict restart.
// Optional same-cycle BTB-update bypass when BRANCH_NOTIF_RECEIVER_BYPASS_EN is defined.
module branch_notif_receiver #(
   parameter int FIFO_DEPTH          = 4,
   parameter int LOG_ROB_ENTRIES     = 5,
   parameter int BTB_PRED_INFO_WIDTH = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           branch_notif_valid,
   input  logic [LOG_ROB_ENTRIES-1:0]     branch_notif_ROB_index,
   input  logic                           branch_notif_is_mispredict,
   input  logic                           branch_notif_is_taken,
   input  logic                           branch_notif_is_out_of_range,
   input  logic                           branch_notif_pred_lru,
   input  logic [BTB_PRED_INFO_WIDTH-1:0] branch_notif_updated_pred_info,
   input  logic [31:0]                    branch_notif_start_PC,
   input  logic [31:0]                    branch_notif_target_PC,
   output logic                           branch_notif_ready,
   input  logic [LOG_ROB_ENTRIES-1:0]     rob_head_index,
   input  logic                           rob_flush,
   output logic                           btb_update_valid,
   output logic [31:0]                    btb_update_start_PC,
   output logic [31:0]                    btb_update_target_PC,
   output logic [BTB_PRED_INFO_WIDTH-1:0] btb_update_pred_info,
   output logic                           btb_update_pred_lru,
   output logic                           btb_update_is_taken,
   input  logic                           btb_update_ready,
   output logic                           restart_valid,
   output logic [31:0]                    restart_PC,
   output logic [LOG_ROB_ENTRIES-1:0]     restart_ROB_index,
   input  logic                           restart_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0]                    start_pc;
      logic [31:0]                    target_pc;
      logic [BTB_PRED_INFO_WIDTH-1:0] info;
      logic                           lru;
      logic                           taken;
   } btb_entry_t;

   btb_entry_t  mem_q [FIFO_DEPTH];
   btb_entry_t  notif_entry, head_entry;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        fifo_empty, fifo_full, fifo_pop, fifo_push, accept, bypass;

   assign notif_entry = '{start_pc:  branch_notif_start_PC,
                          target_pc: branch_notif_target_PC,
                          info:      branch_notif_updated_pred_info,
                          lru:       branch_notif_pred_lru,
                          taken:     branch_notif_is_taken};

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_pop   = !fifo_empty && btb_update_ready;

   assign branch_notif_ready = !fifo_full || fifo_pop;
   assign accept             = branch_notif_valid && branch_notif_ready;

`ifdef BRANCH_NOTIF_RECEIVER_BYPASS_EN
   assign bypass = fifo_empty && btb_update_ready && accept && !branch_notif_is_out_of_range;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push = accept && !branch_notif_is_out_of_range && !bypass;
   assign wr_ptr_d  = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d  = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   // Data outputs read as zero whenever nothing valid is presented.
   always_comb begin
      head_entry = '0;
      if (!fifo_empty)
         head_entry = mem_q[rd_ptr_q[AW-1:0]];
      else if (bypass)
         head_entry = notif_entry;
   end

   assign btb_update_valid     = !fifo_empty || bypass;
   assign btb_update_start_PC  = head_entry.start_pc;
   assign btb_update_target_PC = head_entry.target_pc;
   assign btb_update_pred_info = head_entry.info;
   assign btb_update_pred_lru  = head_entry.lru;
   assign btb_update_is_taken  = head_entry.taken;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_push)
         mem_q[wr_ptr_q[AW-1:0]] <= notif_entry;
   end

   logic                       restart_valid_q, restart_valid_d;
   logic [31:0]                restart_pc_q, restart_pc_d;
   logic [LOG_ROB_ENTRIES-1:0] restart_idx_q, restart_idx_d;
   logic [LOG_ROB_ENTRIES-1:0] age_new, age_pend;
   logic                       restart_load, restart_hs;

   // Ages are distances from the ROB head, so modular wrap is handled by truncation.
   assign age_new      = branch_notif_ROB_index - rob_head_index;
   assign age_pend     = restart_idx_q - rob_head_index;
   assign restart_load = accept && branch_notif_is_mispredict && (!restart_valid_q || (age_new < age_pend));
   assign restart_hs   = restart_valid_q && restart_ready;

   always_comb begin
      restart_valid_d = restart_valid_q;
      restart_pc_d    = restart_pc_q;
      restart_idx_d   = restart_idx_q;
      if (restart_hs)
         restart_valid_d = 1'b0;
      if (restart_load) begin
         restart_valid_d = 1'b1;
         restart_pc_d    = branch_notif_target_PC;
         restart_idx_d   = branch_notif_ROB_index;
      end
      if (rob_flush)
         restart_valid_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST)
         restart_valid_q <= 1'b0;
      else
         restart_valid_q <= restart_valid_d;
   end

   always_ff @(posedge CLK) begin
      restart_pc_q  <= restart_pc_d;
      restart_idx_q <= restart_idx_d;
   end

   assign restart_valid     = restart_valid_q;
   assign restart_PC        = restart_valid_q ? restart_pc_q : '0;
   assign restart_ROB_index = restart_valid_q ? restart_idx_q : '0;

endmodule

// File: tb/tb_branch_notif_receiver.sv
// Scoreboard bench for branch_notif_receiver: stimulus pushes expected BTB updates / restarts, a negedge monitor checks them.
module tb_branch_notif_receiver;
   localparam int DEPTH = 4;
   localparam int LOGR  = 5;
   localparam int INFO  = 8;
`ifdef BRANCH_NOTIF_RECEIVER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST;
   logic            branch_notif_valid;
   logic [LOGR-1:0] branch_notif_ROB_index;
   logic            branch_notif_is_mispredict, branch_notif_is_taken;
   logic            branch_notif_is_out_of_range, branch_notif_pred_lru;
   logic [INFO-1:0] branch_notif_updated_pred_info;
   logic [31:0]     branch_notif_start_PC, branch_notif_target_PC;
   logic            branch_notif_ready;
   logic [LOGR-1:0] rob_head_index;
   logic            rob_flush;
   logic            btb_update_valid;
   logic [31:0]     btb_update_start_PC, btb_update_target_PC;
   logic [INFO-1:0] btb_update_pred_info;
   logic            btb_update_pred_lru, btb_update_is_taken, btb_update_ready;
   logic            restart_valid;
   logic [31:0]     restart_PC;
   logic [LOGR-1:0] restart_ROB_index;
   logic            restart_ready;

   always #5 CLK = ~CLK;

   branch_notif_receiver #(.FIFO_DEPTH(DEPTH), .LOG_ROB_ENTRIES(LOGR), .BTB_PRED_INFO_WIDTH(INFO)) dut (
      .CLK(CLK), .RST(RST),
      .branch_notif_valid(branch_notif_valid),
      .branch_notif_ROB_index(branch_notif_ROB_index),
      .branch_notif_is_mispredict(branch_notif_is_mispredict),
      .branch_notif_is_taken(branch_notif_is_taken),
      .branch_notif_is_out_of_range(branch_notif_is_out_of_range),
      .branch_notif_pred_lru(branch_notif_pred_lru),
      .branch_notif_updated_pred_info(branch_notif_updated_pred_info),
      .branch_notif_start_PC(branch_notif_start_PC),
      .branch_notif_target_PC(branch_notif_target_PC),
      .branch_notif_ready(branch_notif_ready),
      .rob_head_index(rob_head_index),
      .rob_flush(rob_flush),
      .btb_update_valid(btb_update_valid),
      .btb_update_start_PC(btb_update_start_PC),
      .btb_update_target_PC(btb_update_target_PC),
      .btb_update_pred_info(btb_update_pred_info),
      .btb_update_pred_lru(btb_update_pred_lru),
      .btb_update_is_taken(btb_update_is_taken),
      .btb_update_ready(btb_update_ready),
      .restart_valid(restart_valid),
      .restart_PC(restart_PC),
      .restart_ROB_index(restart_ROB_index),
      .restart_ready(restart_ready)
   );

   typedef struct packed {
      logic [31:0]     s;
      logic [31:0]     t;
      logic [INFO-1:0] i;
      logic            l;
      logic            k;
   } btb_t;
   typedef struct packed {
      logic [31:0]     pc;
      logic [LOGR-1:0] idx;
   } rs_t;

   btb_t btb_q[$];
   rs_t  rs_q[$];
   btb_t mon_b, exp_b;
   rs_t  mon_r, exp_r;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every BTB-update or restart handshake must match the head of its queue.
   always @(negedge CLK) begin
      if (btb_update_valid === 1'b1 && btb_update_ready === 1'b1) begin
         mon_b = '{s: btb_update_start_PC, t: btb_update_target_PC, i: btb_update_pred_info,
                   l: btb_update_pred_lru, k: btb_update_is_taken};
         checks++;
         if (btb_q.size() == 0) begin
            errors++;
            $display("FAIL btb_unexpected: got start_PC %0h, no update expected", mon_b.s);
         end else begin
            exp_b = btb_q.pop_front();
            if (mon_b !== exp_b) begin
               errors++;
               $display("FAIL btb_update: got %0h, expected %0h", mon_b, exp_b);
            end
         end
      end
      if (restart_valid === 1'b1 && restart_ready === 1'b1) begin
         mon_r = '{pc: restart_PC, idx: restart_ROB_index};
         checks++;
         if (rs_q.size() == 0) begin
            errors++;
            $display("FAIL restart_unexpected: got PC %0h idx %0d, none expected", mon_r.pc, mon_r.idx);
         end else begin
            exp_r = rs_q.pop_front();
            if (mon_r !== exp_r) begin
               errors++;
               $display("FAIL restart: got PC %0h idx %0d, expected PC %0h idx %0d",
                        mon_r.pc, mon_r.idx, exp_r.pc, exp_r.idx);
            end
         end
      end
   end

   task automatic drive(input logic [LOGR-1:0] idx, input logic mis, input logic oor,
                        input logic [31:0] spc, input logic [31:0] tpc, input logic exp_btb);
      btb_t e;
      e = '{s: spc, t: tpc, i: spc[7:0] ^ 8'h5A, l: spc[3], k: spc[2]};
      branch_notif_valid             = 1'b1;
      branch_notif_ROB_index         = idx;
      branch_notif_is_mispredict     = mis;
      branch_notif_is_out_of_range   = oor;
      branch_notif_start_PC          = e.s;
      branch_notif_target_PC         = e.t;
      branch_notif_updated_pred_info = e.i;
      branch_notif_pred_lru          = e.l;
      branch_notif_is_taken          = e.k;
      if (!oor && exp_btb) btb_q.push_back(e);
   endtask

   task automatic send(input logic [LOGR-1:0] idx, input logic mis, input logic oor,
                       input logic [31:0] spc, input logic [31:0] tpc, input logic exp_btb);
      bit acc = 1'b0;
      int n   = 0;
      drive(idx, mis, oor, spc, tpc, exp_btb);
      while (!acc && n < 50) begin
         @(negedge CLK);
         acc = branch_notif_ready;
         @(posedge CLK); #1;
         n++;
      end
      branch_notif_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: start_PC %0h not accepted, ready stayed %0b", spc, branch_notif_ready);
      end
   endtask

   initial begin
      int n;
      RST = 1'b1;
      branch_notif_valid = 1'b0;
      branch_notif_ROB_index = '0;
      branch_notif_is_mispredict = 1'b0;
      branch_notif_is_taken = 1'b0;
      branch_notif_is_out_of_range = 1'b0;
      branch_notif_pred_lru = 1'b0;
      branch_notif_updated_pred_info = '0;
      branch_notif_start_PC = '0;
      branch_notif_target_PC = '0;
      rob_head_index = '0;
      rob_flush = 1'b0;
      btb_update_ready = 1'b0;
      restart_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_btb_valid", btb_update_valid, 0);
      chk("rst_restart_valid", restart_valid, 0);
      chk("rst_notif_ready", branch_notif_ready, 1);
      chk("rst_btb_start_pc", btb_update_start_PC, 0);
      chk("rst_restart_pc", restart_PC, 0);

      // Fill under backpressure, then release with a simultaneous push/pop while full.
      @(posedge CLK); #1;
      for (int k = 0; k < 4; k++) send(k[LOGR-1:0], 1'b0, 1'b0, 32'h100 + 32'(4 * k), 32'h900 + 32'(k), 1'b1);
      @(negedge CLK);
      chk("full_ready_low", branch_notif_ready, 0);
      chk("full_btb_valid", btb_update_valid, 1);
      @(posedge CLK); #1;
      drive(5'd4, 1'b0, 1'b0, 32'h110, 32'h904, 1'b1);
      @(negedge CLK);
      chk("fifth_blocked", branch_notif_ready, 0);
      @(posedge CLK); #1 btb_update_ready = 1'b1;
      @(negedge CLK);
      chk("ready_with_pop", branch_notif_ready, 1);
      @(posedge CLK); #1 branch_notif_valid = 1'b0;
      n = 0;
      while (btb_q.size() != 0 && n < 50) begin @(posedge CLK); n++; end
      #1;
      chk("drain_complete", btb_q.size(), 0);

      // BTB-update latency from an empty FIFO.
      drive(5'd0, 1'b0, 1'b0, 32'h400, 32'hA00, 1'b1);
      @(negedge CLK);
      chk("latency_accept_cycle", btb_update_valid, BYP);
      @(posedge CLK); #1 branch_notif_valid = 1'b0;
      @(negedge CLK);
      chk("latency_next_cycle", btb_update_valid, !BYP);
      @(posedge CLK); #1;

      // Out-of-range mispredict: restart only, held stable under backpressure.
      send(5'd3, 1'b1, 1'b1, 32'h500, 32'h2000, 1'b1);
      @(negedge CLK);
      chk("oor_restart_valid", restart_valid, 1);
      chk("oor_restart_pc", restart_PC, 32'h2000);
      chk("oor_restart_idx", restart_ROB_index, 3);
      chk("oor_no_btb", btb_update_valid, 0);
      repeat (2) @(negedge CLK);
      chk("oor_restart_hold", restart_PC, 32'h2000);
      @(posedge CLK); #1;
      rs_q.push_back('{pc: 32'h2000, idx: 5'd3});
      restart_ready = 1'b1;
      @(posedge CLK); #1 restart_ready = 1'b0;
      @(negedge CLK);
      chk("oor_restart_cleared", restart_valid, 0);
      @(posedge CLK); #1;

      // Age priority across the ROB wrap point.
      rob_head_index = 5'd30;
      send(5'd2, 1'b1, 1'b0, 32'h600, 32'h3000, 1'b1);
      send(5'd31, 1'b1, 1'b0, 32'h604, 32'h3100, 1'b1);
      send(5'd5, 1'b1, 1'b0, 32'h608, 32'h3200, 1'b1);
      @(negedge CLK);
      chk("age_replaced_idx", restart_ROB_index, 31);
      chk("age_replaced_pc", restart_PC, 32'h3100);
      @(posedge CLK); #1;
      rs_q.push_back('{pc: 32'h3100, idx: 5'd31});
      rs_q.push_back('{pc: 32'h3300, idx: 5'd30});
      restart_ready = 1'b1;
      send(5'd30, 1'b1, 1'b0, 32'h60C, 32'h3300, 1'b1);
      @(posedge CLK); #1 restart_ready = 1'b0;
      @(negedge CLK);
      chk("hs_load_cleared", restart_valid, 0);
      @(posedge CLK); #1;

      // Flush beats a same-cycle load, and clears a pending restart.
      rob_flush = 1'b1;
      send(5'd7, 1'b1, 1'b0, 32'h700, 32'h4000, 1'b1);
      rob_flush = 1'b0;
      @(negedge CLK);
      chk("flush_beats_load", restart_valid, 0);
      @(posedge CLK); #1;
      send(5'd8, 1'b1, 1'b0, 32'h704, 32'h4100, 1'b1);
      @(negedge CLK);
      chk("flush_pending_set", restart_valid, 1);
      @(posedge CLK); #1 rob_flush = 1'b1;
      @(posedge CLK); #1 rob_flush = 1'b0;
      @(negedge CLK);
      chk("flush_pending_cleared", restart_valid, 0);
      @(posedge CLK); #1;

      // Mid-stream reset with three queued entries and a pending restart.
      btb_update_ready = 1'b0;
      send(5'd9, 1'b0, 1'b0, 32'h800, 32'hB00, 1'b0);
      send(5'd10, 1'b1, 1'b0, 32'h804, 32'h5000, 1'b0);
      send(5'd11, 1'b0, 1'b0, 32'h808, 32'hB08, 1'b0);
      @(negedge CLK);
      chk("pre_rst_btb_valid", btb_update_valid, 1);
      chk("pre_rst_restart_valid", restart_valid, 1);
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_btb_valid", btb_update_valid, 0);
      chk("mid_rst_restart_valid", restart_valid, 0);
      chk("mid_rst_notif_ready", branch_notif_ready, 1);
      @(posedge CLK); #1;
      btb_update_ready = 1'b1;
      restart_ready = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      chk("btb_queue_empty", btb_q.size(), 0);
      chk("restart_queue_empty", rs_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, %0d checks done", checks);
      $fatal(1, "timeout");
   end
endmodule
